// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I main control FSM with memory handshake and bus watchdog
module multicycle_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       cond_true,
  input  logic       mem_ready,
  output logic [2:0] ctrl_ALU_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic       bus_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t      state, state_next;
  logic [15:0] wd_cnt, wd_cnt_next;
  logic        req_state, timeout_hit, illegal_set, bus_err_set;

  assign req_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout_hit = req_state && !mem_ready && (wd_cnt == TIMEOUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      wd_cnt        <= '0;
      illegal_instr <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state  <= state_next;
      wd_cnt <= wd_cnt_next;
      if (illegal_set) illegal_instr <= 1'b1;
      if (bus_err_set) bus_err <= 1'b1;
    end
  end

  // Any state change clears the watchdog, covering entry to every request state.
  always_comb begin
    wd_cnt_next = '0;
    if (state_next == state && req_state && !mem_ready) wd_cnt_next = wd_cnt + 16'd1;
  end

  always_comb begin
    state_next  = state;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    ctrl_ALU_op = 3'b000;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
        else if (timeout_hit) begin
          state_next  = S_TRAP;
          bus_err_set = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            state_next  = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = (state == S_MEMWR);
        adr_src = 1'b1;
        if (mem_ready) state_next = (state == S_MEMWR) ? S_FETCH : S_MEMWB;
        else if (timeout_hit) begin
          state_next  = S_TRAP;
          bus_err_set = 1'b1;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        ctrl_ALU_op = 3'b010;
        state_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        ctrl_ALU_op = 3'b001;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        ctrl_ALU_op = 3'b011;
        pc_write    = cond_true;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
    // Gate straight off the reset pin so nothing glitches before the async reset settles.
    if (!rst_n) begin
      ctrl_ALU_op = 3'b000;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      adr_src     = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized check of multicycle_controller against a per-instruction cycle-sequence model
module tb_multicycle_controller;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] ctrl_ALU_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, illegal_instr, bus_err;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_true(cond_true), .mem_ready(mem_ready),
    .ctrl_ALU_op(ctrl_ALU_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  wire [16:0] obs = {ctrl_ALU_op, alu_src_a, alu_src_b, result_src, adr_src, mem_req, mem_we,
                     ir_write, pc_write, reg_write, illegal_instr, bus_err};

  typedef struct {
    logic        rdy_fixed;
    logic        rdy;
    logic        cond_fixed;
    logic        cond;
    logic        opc_valid;
    logic [16:0] exp;
  } cyc_t;

  cyc_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         m_ill = 0;
  bit         m_berr = 0;
  logic [6:0] cur_op;
  logic [6:0] legal [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

  function automatic logic [16:0] v(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] r, input logic adr, input logic req, input logic we,
                                    input logic ir, input logic pc, input logic rw);
    return {op, a, b, r, adr, req, we, ir, pc, rw, m_ill, m_berr};
  endfunction

  task automatic push(input logic rf, input logic rd, input logic cf, input logic c,
                      input logic ov, input logic [16:0] e);
    cyc_t x;
    x.rdy_fixed = rf; x.rdy = rd; x.cond_fixed = cf; x.cond = c; x.opc_valid = ov; x.exp = e;
    q.push_back(x);
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(0, 0, 0, 0, 1, v(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
  endtask

  // A memory access waits 'waits' low cycles; more than T low cycles ends in a bus error.
  task automatic mem_phase(input int waits, input logic [1:0] b, input logic adr, input logic we,
                           input logic upd, input logic ov, output bit trapped);
    int low;
    low = (waits > T) ? T + 1 : waits;
    for (int i = 0; i < low; i++) push(1, 0, 0, 0, ov, v(3'b000, 2'b00, b, 2'b00, adr, 1, we, 0, 0, 0));
    trapped = (waits > T);
    if (trapped) begin
      m_berr = 1;
      push_trap(3);
    end else begin
      push(1, 1, 0, 0, ov, v(3'b000, 2'b00, b, 2'b00, adr, 1, we, upd, upd, 0));
    end
  endtask

  task automatic build(input logic [6:0] opc, input logic c, input int wf, input int wm);
    bit tr;
    q.delete();
    cur_op = opc;
    mem_phase(wf, 2'b10, 0, 0, 1, 0, tr);
    if (tr) return;
    push(0, 0, 0, 0, 1, v(3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    case (opc)
      7'b0000011: begin
        push(0, 0, 0, 0, 1, v(3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        mem_phase(wm, 2'b00, 1, 0, 0, 1, tr);
        if (!tr) push(0, 0, 0, 0, 1, v(3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
      end
      7'b0100011: begin
        push(0, 0, 0, 0, 1, v(3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        mem_phase(wm, 2'b00, 1, 1, 0, 1, tr);
      end
      7'b0110011: begin
        push(0, 0, 0, 0, 1, v(3'b010, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 1, v(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
      end
      7'b0010011: begin
        push(0, 0, 0, 0, 1, v(3'b001, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 1, v(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
      end
      7'b1100011: push(0, 0, 1, c, 1, v(3'b011, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, c, 0));
      7'b1101111: push(0, 0, 0, 0, 1, v(3'b000, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 1));
      default: begin
        m_ill = 1;
        push_trap(3);
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [16:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic play(input int limit);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      mem_ready = q[i].rdy_fixed ? q[i].rdy : 1'($urandom_range(0, 1));
      cond_true = q[i].cond_fixed ? q[i].cond : 1'($urandom_range(0, 1));
      opcode    = q[i].opc_valid ? cur_op : 7'($urandom);
      #1;
      check($sformatf("op%b_cyc%0d", cur_op, i), q[i].exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    m_ill = 0;
    m_berr = 0;
    #1;
    check("reset_async", 17'h0);
    @(posedge clk);
    #1;
    check("reset_held", 17'h0);
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [6:0] opc, input logic c, input int wf, input int wm);
    build(opc, c, wf, wm);
    play(q.size());
    if (m_ill || m_berr) do_reset();
  endtask

  initial begin
    #6;
    do_reset();
    run(7'b0110011, 0, 0, 0);
    run(7'b0000011, 0, 0, 3);
    run(7'b1100011, 1, 0, 0);
    run(7'b1100011, 0, 0, 0);
    run(7'b1101111, 0, 1, 0);
    run(7'b0100011, 0, 0, 4);
    run(7'b0001111, 0, 0, 0);
    run(7'b0110011, 0, 5, 0);
    run(7'b0010011, 0, 4, 0);
    build(7'b0100011, 0, 0, 3);
    play(5);
    do_reset();
    for (int n = 0; n < 90; n++) begin
      int k;
      logic [6:0] opc;
      k = $urandom_range(0, 7);
      opc = (k < 6) ? legal[k] : 7'($urandom);
      run(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
